// File: rtl/debounce_edge_pkg.sv
// Shared types for the input debouncer and any future
// multi-bit debouncer bank.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'b00,
    RISING  = 2'b01,
    HIGH    = 2'b10,
    FALLING = 2'b11
  } db_state_t;

  function automatic logic level_of(db_state_t s);
    return (s == HIGH) || (s == FALLING);
  endfunction

endpackage

// File: rtl/debounce_edge_if.sv
// Raw input in, debounced level and event pulses out.
interface debounce_edge_if #(
  parameter int GCNT_W = 8
);

  logic              d_i;
  logic              level_o;
  logic              rise_o;
  logic              fall_o;
  logic              glitch_o;
  logic [GCNT_W-1:0] glitch_cnt_o;

  modport master (
    output d_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  glitch_o,
    input  glitch_cnt_o
  );

  modport slave (
    input  d_i,
    output level_o,
    output rise_o,
    output fall_o,
    output glitch_o,
    output glitch_cnt_o
  );

endinterface

// File: rtl/debounce_edge_sync.sv
// N-flop synchroniser for one asynchronous bit,
// synchronous active-high reset to 0.
module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronise, stability-filter and edge-detect one raw
// input; count rejected transitions with saturation.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GCNT_W        = 8
) (
  input logic            clk,
  input logic            rst,
  debounce_edge_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic              d_sync;
  db_state_t         state;
  logic [CW-1:0]     cnt;
  logic              rise;
  logic              fall;
  logic              glitch;
  logic [GCNT_W-1:0] gcnt;

  sync_chain #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.d_i),
    .q   (d_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOW;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
      gcnt   <= '0;
    end else begin
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
      unique case (state)
        LOW: begin
          if (d_sync) begin
            if (STABLE_CYCLES == 1) begin
              state <= HIGH;
              rise  <= 1'b1;
            end else begin
              state <= RISING;
              cnt   <= ONE;
            end
          end
        end
        RISING: begin
          if (!d_sync) begin
            state  <= LOW;
            cnt    <= '0;
            glitch <= 1'b1;
            if (gcnt != '1) gcnt <= gcnt + 1'b1;
          end else if (cnt == LAST) begin
            state <= HIGH;
            cnt   <= '0;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!d_sync) begin
            if (STABLE_CYCLES == 1) begin
              state <= LOW;
              fall  <= 1'b1;
            end else begin
              state <= FALLING;
              cnt   <= ONE;
            end
          end
        end
        FALLING: begin
          if (d_sync) begin
            state  <= HIGH;
            cnt    <= '0;
            glitch <= 1'b1;
            if (gcnt != '1) gcnt <= gcnt + 1'b1;
          end else if (cnt == LAST) begin
            state <= LOW;
            cnt   <= '0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.level_o      = level_of(state);
  assign bus.rise_o       = rise;
  assign bus.fall_o       = fall;
  assign bus.glitch_o     = glitch;
  assign bus.glitch_cnt_o = gcnt;

endmodule
